// File: rtl/jups_pkg.sv
// Shared definitions for the JUPS program sequencer: state encoding and default sizes.
package jups_pkg;

    localparam int unsigned JUPS_ADDR_W    = 32;
    localparam int unsigned JUPS_RAS_DEPTH = 8;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_WAIT_IN = 2'd1,
        ST_HALTED  = 2'd2
    } seq_state_e;

endpackage

// File: rtl/jups_ras.sv
// Circular return-address stack; a push onto a full stack overwrites the oldest entry.
module jups_ras
    import jups_pkg::*;
#(
    parameter int unsigned ADDR_W    = JUPS_ADDR_W,
    parameter int unsigned RAS_DEPTH = JUPS_RAS_DEPTH
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [ADDR_W-1:0] i_data,
    output logic [ADDR_W-1:0] o_data,
    output logic              o_empty,
    output logic              o_overflow,
    output logic              o_underflow
);

    localparam int unsigned    PTR_W    = $clog2(RAS_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(RAS_DEPTH);

    logic [ADDR_W-1:0] r_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  r_wp;
    logic [PTR_W:0]    r_cnt;
    logic              r_ovf;
    logic              r_unf;

    logic              w_full;
    logic              w_do_push;
    logic              w_do_pop;
    logic [PTR_W-1:0]  w_top;

    assign o_empty     = (r_cnt == '0);
    assign w_full      = (r_cnt == FULL_CNT);
    assign w_top       = r_wp - PTR_W'(1);
    assign o_data      = r_mem[w_top];
    assign w_do_pop    = i_pop & ~o_empty;
    assign w_do_push   = i_push & ~i_pop;
    assign o_overflow  = r_ovf;
    assign o_underflow = r_unf;

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wp] <= i_data;
        end
    end

    // Write pointer always advances on push; when full it lands on the oldest slot.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wp  <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_wp <= r_wp + PTR_W'(1);
                if (w_full) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + (PTR_W + 1)'(1);
                end
            end else if (w_do_pop) begin
                r_wp  <= w_top;
                r_cnt <= r_cnt - (PTR_W + 1)'(1);
            end
            if (i_pop && o_empty) begin
                r_unf <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/jups_sequencer.sv
// Program-counter sequencer with RUN / WAIT_IN / HALTED control, button-gated input
// handshake and a return-address stack for jal/ret.
module jups_sequencer
    import jups_pkg::*;
#(
    parameter int unsigned       ADDR_W    = JUPS_ADDR_W,
    parameter int unsigned       RAS_DEPTH = JUPS_RAS_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic              Clock,
    input  logic              n_reset,
    input  logic              step_en,
    input  logic              branch,
    input  logic              zero,
    input  logic              j,
    input  logic              jal,
    input  logic              jr,
    input  logic              ret,
    input  logic              halt_req,
    input  logic              in_req,
    input  logic              button,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] ret_addr,
    output logic [1:0]        state_out,
    output logic              in_ack,
    output logic              ras_overflow,
    output logic              ras_underflow
);

    logic [1:0]        r_rst_sync;
    seq_state_e        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic              r_btn;
    logic              r_edge;

    seq_state_e        w_state_nxt;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_ras_data;
    logic              w_ras_empty;
    logic              w_live;
    logic              w_step;
    logic              w_rise;
    logic              w_push;
    logic              w_pop;
    logic              w_in_ack;
    logic              w_edge_clr;

    assign w_live   = r_rst_sync[1];
    assign w_step   = step_en & w_live;
    assign w_rise   = button & ~r_btn;
    assign w_pc_inc = r_pc + ADDR_W'(1);

    assign pc_out    = r_pc;
    assign ret_addr  = w_pc_inc;
    assign state_out = r_state;
    assign in_ack    = w_in_ack;

    // Reset asserts immediately; release only takes effect after two clock edges.
    always_ff @(posedge Clock or negedge n_reset) begin
        if (!n_reset) begin
            r_rst_sync <= '0;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    always_ff @(posedge Clock or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    // Edge flag is cleared on entry to WAIT_IN so presses made before the IN are discarded.
    always_ff @(posedge Clock or negedge n_reset) begin
        if (!n_reset) begin
            r_btn  <= 1'b0;
            r_edge <= 1'b0;
        end else if (w_live) begin
            r_btn <= button;
            if (w_edge_clr) begin
                r_edge <= 1'b0;
            end else if (w_rise) begin
                r_edge <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_in_ack    = 1'b0;
        w_edge_clr  = 1'b0;
        if (w_step) begin
            case (r_state)
                ST_RUN: begin
                    if (halt_req) begin
                        w_state_nxt = ST_HALTED;
                    end else if (in_req) begin
                        w_state_nxt = ST_WAIT_IN;
                        w_edge_clr  = 1'b1;
                    end else if (ret) begin
                        w_pop    = 1'b1;
                        w_pc_nxt = w_ras_empty ? w_pc_inc : w_ras_data;
                    end else if (jr || j || jal) begin
                        w_push   = jal;
                        w_pc_nxt = target;
                    end else if (branch && zero) begin
                        w_pc_nxt = target;
                    end else begin
                        w_pc_nxt = w_pc_inc;
                    end
                end
                ST_WAIT_IN: begin
                    if (r_edge) begin
                        w_in_ack    = 1'b1;
                        w_pc_nxt    = w_pc_inc;
                        w_state_nxt = ST_RUN;
                        w_edge_clr  = 1'b1;
                    end
                end
                ST_HALTED: begin
                    w_state_nxt = ST_HALTED;
                end
                default: begin
                    w_state_nxt = ST_RUN;
                end
            endcase
        end
    end

    jups_ras #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .i_clk       (Clock),
        .i_rst_n     (n_reset),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_data      (w_pc_inc),
        .o_data      (w_ras_data),
        .o_empty     (w_ras_empty),
        .o_overflow  (ras_overflow),
        .o_underflow (ras_underflow)
    );

endmodule
